nids_alert_manager: RTL and testbench

Multi-channel alert aggregator for the NIDS datapath. It collects per-packet verdicts from up to NUM_CH detector engines (CNN classifiers, anomaly autoencoders) and applies per-channel enable masks and hold-off suppression. Qualified alerts are arbitrated round-robin into a record FIFO and serialized as 4-byte framed records over a valid/ready byte stream feeding the UART transmitter. It replaces the single-bit 0xFF/0x00 alert byte with a channel-tagged, checksummed report plus loss accounting.

---
 rtl/nids_alert_manager_if.sv | 19 +
 rtl/nids_alert_manager.sv | 185 ++++++++++++++++++
 tb/tb_nids_alert_manager.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/nids_alert_manager_if.sv
// Detector verdict inputs and the framed record byte stream of the alert manager.
// The slave modport is the alert manager's view; master is the surrounding datapath.
interface nids_alert_manager_if #(
    parameter int NUM_CH  = 4,
    parameter int CLASS_W = 8
);
    logic [NUM_CH-1:0]         det_valid;
    logic [NUM_CH-1:0]         det_anomaly;
    logic [NUM_CH*CLASS_W-1:0] det_class;
    logic [NUM_CH-1:0]         cfg_enable;
    logic [7:0]                tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (output det_valid, det_anomaly, det_class, cfg_enable, tx_ready,
                    input  tx_data, tx_valid);
    modport slave  (input  det_valid, det_anomaly, det_class, cfg_enable, tx_ready,
                    output tx_data, tx_valid);
endinterface

// File: rtl/nids_alert_manager.sv
// Multi-channel alert aggregator: qualify, hold-off, pending latch, round-robin
// into a record FIFO, then serialize each record as A5 / CHAN / CLASS / CSUM bytes.
module nids_alert_manager #(
    parameter int NUM_CH     = 4,
    parameter int CLASS_W    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int HOLDOFF    = 1024
) (
    input  logic                        clk_125mhz,
    input  logic                        rst,
    nids_alert_manager_if.slave         bus,
    output logic                        alert_active,
    output logic [15:0]                 drop_count,
    output logic [15:0]                 supp_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_CHAN, S_CLASS, S_CSUM} state_e;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] n);
        logic [16:0] s;
        s = {1'b0, a} + {12'd0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [NUM_CH-1:0] pv_q, pv_d;
    logic [HW-1:0]     hold_q [NUM_CH];
    logic [HW-1:0]     hold_d [NUM_CH];
    logic [CW-1:0]     rr_q, rr_d;
    logic [AW:0]       wp_q, rp_q;
    state_e            state_q, state_d;
    logic              alert_q;
    logic [15:0]       drop_q, supp_q;

    logic              pa_q  [NUM_CH];
    logic [7:0]        pc_q  [NUM_CH];
    logic [12:0]       mem_q [FIFO_DEPTH];
    logic [12:0]       rec_q;

    logic [NUM_CH-1:0] qual, blocked, latch, gnt_oh, drop_v;
    logic [7:0]        cls_ext [NUM_CH];
    logic [4:0]        ndrop;
    logic              gnt_vld, push, pop, full, empty, can_push;
    logic [CW-1:0]     gnt_ch;
    logic [AW:0]       level;
    logic [12:0]       push_data;
    logic [7:0]        chan_byte, csum_byte, tx_byte;
    logic              tx_vld;

    // Stage p0: qualification and hold-off
    always_comb begin
        qual    = '0;
        blocked = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cls_ext[c] = '0;
            cls_ext[c][CLASS_W-1:0] = bus.det_class[c*CLASS_W +: CLASS_W];
            qual[c]    = bus.det_valid[c] & bus.cfg_enable[c] &
                         (bus.det_anomaly[c] | (cls_ext[c] != 8'd0));
            blocked[c] = (hold_q[c] != '0);
            hold_d[c]  = hold_q[c];
            if (qual[c] && !blocked[c])
                hold_d[c] = HW'(HOLDOFF);
            else if (hold_q[c] != '0)
                hold_d[c] = hold_q[c] - HW'(1);
        end
        latch = qual & ~blocked;
    end

    assign level = wp_q - rp_q;
    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign empty = (wp_q == rp_q);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign can_push = !full || pop;

    // Stage p1: round-robin grant from the pending registers into the FIFO
    always_comb begin
        logic [CW:0] s;
        s       = '0;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            s = {1'b0, rr_q} + (CW+1)'(k);
            if (s >= (CW+1)'(NUM_CH))
                s = s - (CW+1)'(NUM_CH);
            if (!gnt_vld && pv_q[s[CW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_ch  = s[CW-1:0];
            end
        end
        push      = gnt_vld & can_push;
        gnt_oh    = push ? (NUM_CH'(1) << gnt_ch) : '0;
        push_data = {4'(gnt_ch), pa_q[gnt_ch], pc_q[gnt_ch]};
        rr_d      = rr_q;
        if (push)
            rr_d = (gnt_ch == CW'(NUM_CH - 1)) ? '0 : gnt_ch + CW'(1);
        pv_d   = latch | (pv_q & ~gnt_oh);
        drop_v = latch & pv_q & ~gnt_oh;
        ndrop  = '0;
        for (int c = 0; c < NUM_CH; c++)
            ndrop = ndrop + 5'(drop_v[c]);
    end

    assign chan_byte = {rec_q[12:9], 3'b000, rec_q[8]};
    assign csum_byte = SYNC_BYTE ^ chan_byte ^ rec_q[7:0];

    // Stage p2: serializer; IDLE pops only once the sink is ready so backlog stays in the FIFO
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        tx_vld  = (state_q != S_IDLE);
        tx_byte = 8'h00;
        case (state_q)
            S_IDLE: if (!empty && bus.tx_ready) begin
                pop     = 1'b1;
                state_d = S_SYNC;
            end
            S_SYNC: begin
                tx_byte = SYNC_BYTE;
                if (bus.tx_ready) state_d = S_CHAN;
            end
            S_CHAN: begin
                tx_byte = chan_byte;
                if (bus.tx_ready) state_d = S_CLASS;
            end
            S_CLASS: begin
                tx_byte = rec_q[7:0];
                if (bus.tx_ready) state_d = S_CSUM;
            end
            S_CSUM: begin
                tx_byte = csum_byte;
                if (bus.tx_ready) begin
                    pop     = !empty;
                    state_d = empty ? S_IDLE : S_SYNC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            pv_q    <= '0;
            rr_q    <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            state_q <= S_IDLE;
            alert_q <= 1'b0;
            drop_q  <= '0;
            supp_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) hold_q[c] <= '0;
        end else begin
            pv_q    <= pv_d;
            rr_q    <= rr_d;
            wp_q    <= wp_q + (AW+1)'(push);
            rp_q    <= rp_q + (AW+1)'(pop);
            state_q <= state_d;
            alert_q <= |qual;
            drop_q  <= sat_add(drop_q, ndrop);
            supp_q  <= sat_add(supp_q, {4'd0, |(qual & blocked)});
            for (int c = 0; c < NUM_CH; c++) hold_q[c] <= hold_d[c];
        end
    end

    always_ff @(posedge clk_125mhz) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (latch[c]) begin
                pa_q[c] <= bus.det_anomaly[c];
                pc_q[c] <= cls_ext[c];
            end
        end
        if (push) mem_q[wp_q[AW-1:0]] <= push_data;
        if (pop)  rec_q <= mem_q[rp_q[AW-1:0]];
    end

    assign bus.tx_valid = tx_vld;
    assign bus.tx_data  = tx_byte;
    assign alert_active = alert_q;
    assign drop_count   = drop_q;
    assign supp_count   = supp_q;
    assign fifo_level   = level;
endmodule

// File: tb/tb_nids_alert_manager.sv
// Directed bench for nids_alert_manager: three instances cover default, short hold-off
// and a two-entry FIFO; accepted bytes are collected per instance and compared to tables.
module tb_nids_alert_manager;
    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    nids_alert_manager_if #(.NUM_CH(4), .CLASS_W(8)) bus_m ();
    nids_alert_manager_if #(.NUM_CH(4), .CLASS_W(8)) bus_h ();
    nids_alert_manager_if #(.NUM_CH(4), .CLASS_W(8)) bus_o ();

    logic        act_m, act_h, act_o;
    logic [15:0] drop_m, drop_h, drop_o, supp_m, supp_h, supp_o;
    logic [4:0]  lvl_m, lvl_h;
    logic [1:0]  lvl_o;

    nids_alert_manager u_main (
        .clk_125mhz(clk), .rst(rst), .bus(bus_m), .alert_active(act_m),
        .drop_count(drop_m), .supp_count(supp_m), .fifo_level(lvl_m));
    nids_alert_manager #(.HOLDOFF(8)) u_ho (
        .clk_125mhz(clk), .rst(rst), .bus(bus_h), .alert_active(act_h),
        .drop_count(drop_h), .supp_count(supp_h), .fifo_level(lvl_h));
    nids_alert_manager #(.FIFO_DEPTH(2), .HOLDOFF(0)) u_ov (
        .clk_125mhz(clk), .rst(rst), .bus(bus_o), .alert_active(act_o),
        .drop_count(drop_o), .supp_count(supp_o), .fifo_level(lvl_o));

    logic [7:0] qb_m[$], qb_h[$], qb_o[$];
    int         qt_m[$];

    always @(negedge clk) begin
        if (bus_m.tx_valid && bus_m.tx_ready) begin
            qb_m.push_back(bus_m.tx_data);
            qt_m.push_back(cyc);
        end
        if (bus_h.tx_valid && bus_h.tx_ready) qb_h.push_back(bus_h.tx_data);
        if (bus_o.tx_valid && bus_o.tx_ready) qb_o.push_back(bus_o.tx_data);
    end

    logic [7:0] e1 [16] = '{8'hA5,8'h20,8'h07,8'h82, 8'h00,8'h00,8'h00,8'h00,
                            8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00};
    logic [7:0] e2 [16] = '{8'hA5,8'h01,8'h00,8'hA4, 8'hA5,8'h11,8'h00,8'hB4,
                            8'hA5,8'h21,8'h00,8'h84, 8'hA5,8'h31,8'h00,8'h94};
    logic [7:0] e3 [16] = '{8'hA5,8'h11,8'h3C,8'h88, 8'h00,8'h00,8'h00,8'h00,
                            8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00};
    logic [7:0] e4 [16] = '{8'hA5,8'h01,8'h00,8'hA4, 8'hA5,8'h01,8'h00,8'hA4,
                            8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00};
    logic [7:0] e5 [16] = '{8'hA5,8'h10,8'h01,8'hB4, 8'hA5,8'h10,8'h02,8'hB7,
                            8'hA5,8'h10,8'h05,8'hB0, 8'h00,8'h00,8'h00,8'h00};
    logic [7:0] e6 [16] = '{8'hA5,8'h30,8'h55,8'hC0, 8'h00,8'h00,8'h00,8'h00,
                            8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // which: 0 = main, 1 = hold-off instance, 2 = overflow instance
    task automatic check_rec(input string tag, input int which, input int base,
                             input logic [7:0] e [16], input int n);
        int         sz;
        logic [7:0] b;
        sz = (which == 0) ? qb_m.size() : (which == 1) ? qb_h.size() : qb_o.size();
        check_eq({tag, "_nbytes"}, 32'(sz - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < sz) begin
                b = (which == 0) ? qb_m[base+i] : (which == 1) ? qb_h[base+i] : qb_o[base+i];
                check_eq($sformatf("%s_b%0d", tag, i), {24'd0, b}, {24'd0, e[i]});
            end
        end
    endtask

    task automatic idle_inputs();
        bus_m.det_valid = '0; bus_m.det_anomaly = '0; bus_m.det_class = '0;
        bus_m.cfg_enable = 4'hF; bus_m.tx_ready = 1'b1;
        bus_h.det_valid = '0; bus_h.det_anomaly = '0; bus_h.det_class = '0;
        bus_h.cfg_enable = 4'hF; bus_h.tx_ready = 1'b1;
        bus_o.det_valid = '0; bus_o.det_anomaly = '0; bus_o.det_class = '0;
        bus_o.cfg_enable = 4'hF; bus_o.tx_ready = 1'b1;
    endtask

    initial begin
        int b0, t0, bad, gaps;
        idle_inputs();
        do_reset();
        check_eq("rst_tx_valid", {31'd0, bus_m.tx_valid}, 32'd0);
        check_eq("rst_tx_data", {24'd0, bus_m.tx_data}, 32'd0);
        check_eq("rst_alert", {31'd0, act_m}, 32'd0);
        check_eq("rst_drop", {16'd0, drop_m}, 32'd0);
        check_eq("rst_supp", {16'd0, supp_m}, 32'd0);
        check_eq("rst_level", {27'd0, lvl_m}, 32'd0);

        // Single alert on ch2, class 7
        b0 = qb_m.size(); t0 = cyc;
        bus_m.det_valid = 4'b0100; bus_m.det_class = 32'h0007_0000;
        tick(1);
        bus_m.det_valid = '0;
        check_eq("single_alert_active", {31'd0, act_m}, 32'd1);
        tick(1);
        check_eq("single_level_t2", {27'd0, lvl_m}, 32'd1);
        tick(8);
        check_rec("single", 0, b0, e1, 4);
        check_eq("single_first_cycle", 32'(qt_m[b0] - t0), 32'd3);
        check_eq("single_last_cycle", 32'(qt_m[b0+3] - t0), 32'd6);
        check_eq("single_level_end", {27'd0, lvl_m}, 32'd0);

        // Round-robin: all channels in one cycle
        do_reset();
        b0 = qb_m.size(); t0 = cyc;
        bus_m.det_valid = 4'hF; bus_m.det_anomaly = 4'hF; bus_m.det_class = '0;
        tick(1);
        bus_m.det_valid = '0; bus_m.det_anomaly = '0;
        tick(24);
        check_rec("rr", 0, b0, e2, 16);
        gaps = 0;
        for (int i = 1; i < 16; i++)
            if (b0 + i < qt_m.size() && qt_m[b0+i] != qt_m[b0+i-1] + 1) gaps++;
        check_eq("rr_gaps", 32'(gaps), 32'd0);
        check_eq("rr_first_cycle", 32'(qt_m[b0] - t0), 32'd3);
        check_eq("rr_drop", {16'd0, drop_m}, 32'd0);

        // Backpressure during the CLASS byte
        do_reset();
        b0 = qb_m.size(); t0 = cyc;
        bus_m.det_valid = 4'b0010; bus_m.det_anomaly = 4'b0010; bus_m.det_class = 32'h0000_3C00;
        tick(1);
        bus_m.det_valid = '0; bus_m.det_anomaly = '0;
        tick(4);
        bus_m.tx_ready = 1'b0;
        bad = 0;
        repeat (20) begin
            if (!(bus_m.tx_valid && bus_m.tx_data == 8'h3C)) bad++;
            tick(1);
        end
        check_eq("bp_hold_class", 32'(bad), 32'd0);
        bus_m.tx_ready = 1'b1;
        tick(5);
        check_rec("bp", 0, b0, e3, 4);

        // Hold-off window of 8 cycles: alerts at 0, 4, 9
        do_reset();
        b0 = qb_h.size();
        bus_h.det_valid = 4'b0001; bus_h.det_anomaly = 4'b0001;
        tick(1);
        bus_h.det_valid = '0;
        tick(3);
        bus_h.det_valid = 4'b0001;
        tick(1);
        bus_h.det_valid = '0;
        check_eq("ho_alert_suppressed", {31'd0, act_h}, 32'd1);
        tick(4);
        bus_h.det_valid = 4'b0001;
        tick(1);
        bus_h.det_valid = '0; bus_h.det_anomaly = '0;
        tick(15);
        check_eq("ho_supp", {16'd0, supp_h}, 32'd1);
        check_eq("ho_drop", {16'd0, drop_h}, 32'd0);
        check_rec("ho", 1, b0, e4, 8);

        // Overflow: two-entry FIFO, sink stalled
        do_reset();
        bus_o.tx_ready = 1'b0;
        b0 = qb_o.size();
        for (int k = 1; k <= 5; k++) begin
            bus_o.det_valid = 4'b0010;
            bus_o.det_class = {16'd0, 8'(k), 8'd0};
            tick(1);
        end
        bus_o.det_valid = '0; bus_o.det_class = '0;
        tick(3);
        check_eq("ov_level", {30'd0, lvl_o}, 32'd2);
        check_eq("ov_drop", {16'd0, drop_o}, 32'd2);
        check_eq("ov_tx_idle", {31'd0, bus_o.tx_valid}, 32'd0);
        bus_o.tx_ready = 1'b1;
        tick(20);
        check_rec("ov", 2, b0, e5, 12);
        check_eq("ov_level_end", {30'd0, lvl_o}, 32'd0);

        // Reset in the middle of a record
        do_reset();
        bus_m.det_valid = 4'b1000; bus_m.det_class = 32'h5500_0000;
        tick(2);
        bus_m.det_valid = '0;
        tick(2);
        check_eq("mid_chan_byte", {24'd0, bus_m.tx_data}, 32'h30);
        check_eq("mid_supp_before", {16'd0, supp_m}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("mid_tx_valid", {31'd0, bus_m.tx_valid}, 32'd0);
        check_eq("mid_supp", {16'd0, supp_m}, 32'd0);
        check_eq("mid_drop", {16'd0, drop_m}, 32'd0);
        check_eq("mid_level", {27'd0, lvl_m}, 32'd0);
        b0 = qb_m.size();
        bus_m.det_valid = 4'b1000;
        tick(1);
        bus_m.det_valid = '0;
        tick(9);
        check_rec("mid_new", 0, b0, e6, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
